// File: rtl/input_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : input_window_streamer
// Purpose  : Fetches image rows over an AXI4 read channel into a ring of K+1
//            line slots and streams KxK sliding windows (stride 1, no padding)
//            per row band and per layer, tagged with the top-left pixel.
// Ports    : clk, reset_n (sync, active-low)
//            start_i, base_addr_i, num_layers_i/rows_i/cols_i : job setup
//            busy_o, done_o                                   : job status
//            M_axi_ar*_o / M_axi_arready_i                    : AXI4 AR
//            M_axi_r*_i / M_axi_rready_o                      : AXI4 R
//            win_data_o, win_valid_o, win_ready_i,
//            win_layer_o, win_row_o, win_col_o                : window stream
// Revision : 1.0 - initial release
// ============================================================================
module input_window_streamer #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int PIX_W      = 8,
  parameter int K          = 3,
  parameter int MAX_COLS   = 64,
  parameter int ROW_SH     = 6,
  parameter int LAYER_SH   = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_i,
  input  logic [AXI_ADDR_W-1:0]   base_addr_i,
  input  logic [9:0]              num_layers_i,
  input  logic [9:0]              num_rows_i,
  input  logic [9:0]              num_cols_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [3:0]              M_axi_arid_o,
  output logic [AXI_ADDR_W-1:0]   M_axi_araddr_o,
  output logic [7:0]              M_axi_arlen_o,
  output logic [2:0]              M_axi_arsize_o,
  output logic [1:0]              M_axi_arburst_o,
  output logic                    M_axi_arlock_o,
  output logic [3:0]              M_axi_arcache_o,
  output logic [2:0]              M_axi_arprot_o,
  output logic [3:0]              M_axi_arqos_o,
  output logic                    M_axi_arvalid_o,
  input  logic                    M_axi_arready_i,
  input  logic [AXI_DATA_W-1:0]   M_axi_rdata_i,
  input  logic [1:0]              M_axi_rresp_i,
  input  logic                    M_axi_rlast_i,
  input  logic                    M_axi_rvalid_i,
  output logic                    M_axi_rready_o,
  output logic [K*K*PIX_W-1:0]    win_data_o,
  output logic                    win_valid_o,
  input  logic                    win_ready_i,
  output logic [9:0]              win_layer_o,
  output logic [9:0]              win_row_o,
  output logic [9:0]              win_col_o
);

  localparam int PPB   = AXI_DATA_W / PIX_W;
  localparam int SLOTS = K + 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int CW    = $clog2(SLOTS + 1);
  localparam int CIW   = $clog2(MAX_COLS);
  localparam logic [9:0] KP  = 10'(K);
  localparam logic [9:0] KM1 = 10'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    busy_q, done_q, degen_q;
  logic [AXI_ADDR_W-1:0]   base_q, araddr_q;
  logic [9:0]              nl_q, nr_q, nc_q;
  logic [7:0]              arlen_q, beat_q;
  logic                    arvalid_q, rready_q;
  // Fetch cursor: band, layer, row offset within the band.
  logic [9:0]              fb_q, fl_q, fk_q, fb_d, fl_d, fk_d;
  // Consumer cursor: band, layer, column of the next window.
  logic [9:0]              cb_q, cl_q, cc_q;
  logic                    cons_done_q;
  logic [SW-1:0]           wp_q, rp_q;
  logic [CW-1:0]           nvalid_q, w_nvalid_d, w_free;
  logic                    win_valid_q, win_last_q;
  logic [K*K*PIX_W-1:0]    win_data_q, w_win;
  logic [9:0]              win_layer_q, win_row_q, win_col_q;
  logic                    w_fetch_last, w_unit_end, w_cons_last;
  logic                    w_avail, w_load, w_rbeat, w_rlast_hs, w_win_hs;
  logic                    w_unused;

  logic [PIX_W-1:0]        lb_q [SLOTS][MAX_COLS];

  function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= SLOTS) s = s - SLOTS;
    return SW'(s);
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] row_addr(input logic [AXI_ADDR_W-1:0] b,
                                                     input logic [9:0] l, input logic [9:0] r);
    return b + (AXI_ADDR_W'(l) << LAYER_SH) + (AXI_ADDR_W'(r) << ROW_SH);
  endfunction

  assign w_unused   = ^M_axi_rresp_i;
  assign w_rbeat    = (state_q == S_R) && M_axi_rvalid_i && rready_q;
  assign w_rlast_hs = w_rbeat && M_axi_rlast_i;
  assign w_win_hs   = win_valid_q && win_ready_i;

  // Advance of the fetch cursor. A single-layer job keeps K-1 rows resident
  // across bands, so after band 0 only the bottom row of each band is fetched.
  always_comb begin
    fb_d = fb_q;
    fl_d = fl_q;
    fk_d = fk_q + 10'd1;
    if (fk_q == KM1) begin
      fk_d = 10'd0;
      if (fl_q == nl_q - 10'd1) begin
        fl_d = 10'd0;
        fb_d = fb_q + 10'd1;
        if (nl_q == 10'd1) fk_d = KM1;
      end else begin
        fl_d = fl_q + 10'd1;
      end
    end
  end

  assign w_fetch_last = (fk_q == KM1) && (fl_q == nl_q - 10'd1) && (fb_q == nr_q - KP);
  assign w_unit_end   = (cc_q == nc_q - KP);
  assign w_cons_last  = w_unit_end && (cl_q == nl_q - 10'd1) && (cb_q == nr_q - KP);
  // The K oldest resident rows are always exactly the rows of the current unit.
  assign w_avail      = busy_q && !degen_q && !cons_done_q && (nvalid_q >= CW'(K));
  assign w_load       = w_avail && (!win_valid_q || win_ready_i);
  // Rows are released once the last window of a unit is captured in the
  // output register; multi-layer jobs release the whole unit.
  assign w_free       = (w_load && w_unit_end) ? ((nl_q == 10'd1) ? CW'(1) : CW'(K)) : '0;
  assign w_nvalid_d   = nvalid_q + CW'(w_rlast_hs) - w_free;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_win[(K*K-1-(i*K+j))*PIX_W +: PIX_W] = lb_q[slot_add(rp_q, i)][CIW'(int'(cc_q) + j)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_rbeat) begin
      for (int j = 0; j < PPB; j++) begin
        if (int'(beat_q) * PPB + j < MAX_COLS)
          lb_q[wp_q][CIW'(int'(beat_q) * PPB + j)] <= M_axi_rdata_i[j*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;     busy_q <= 1'b0;     done_q <= 1'b0;      degen_q <= 1'b0;
      base_q <= '0;          araddr_q <= '0;     arlen_q <= '0;       beat_q <= '0;
      nl_q <= '0;            nr_q <= '0;         nc_q <= '0;
      arvalid_q <= 1'b0;     rready_q <= 1'b0;
      fb_q <= '0;            fl_q <= '0;         fk_q <= '0;
      cb_q <= '0;            cl_q <= '0;         cc_q <= '0;          cons_done_q <= 1'b0;
      wp_q <= '0;            rp_q <= '0;         nvalid_q <= '0;
      win_valid_q <= 1'b0;   win_last_q <= 1'b0; win_data_q <= '0;
      win_layer_q <= '0;     win_row_q <= '0;    win_col_q <= '0;
    end else begin
      done_q   <= 1'b0;
      nvalid_q <= w_nvalid_d;
      if (w_win_hs) win_valid_q <= 1'b0;
      if (w_load) begin
        win_valid_q <= 1'b1;
        win_data_q  <= w_win;
        win_layer_q <= cl_q;
        win_row_q   <= cb_q;
        win_col_q   <= cc_q;
        win_last_q  <= w_cons_last;
        if (w_unit_end) begin
          cc_q <= '0;
          rp_q <= slot_add(rp_q, (nl_q == 10'd1) ? 1 : K);
          if (cl_q == nl_q - 10'd1) begin
            cl_q <= '0;
            cb_q <= cb_q + 10'd1;
          end else begin
            cl_q <= cl_q + 10'd1;
          end
          if (w_cons_last) cons_done_q <= 1'b1;
        end else begin
          cc_q <= cc_q + 10'd1;
        end
      end

      case (state_q)
        S_IDLE: if (start_i) begin
          busy_q  <= 1'b1;
          base_q  <= base_addr_i;
          nl_q    <= num_layers_i;
          nr_q    <= num_rows_i;
          nc_q    <= num_cols_i;
          arlen_q <= 8'((num_cols_i - 10'd1) / 10'(PPB));
          fb_q <= '0; fl_q <= '0; fk_q <= '0;
          cb_q <= '0; cl_q <= '0; cc_q <= '0;
          wp_q <= '0; rp_q <= '0; nvalid_q <= '0;
          cons_done_q <= 1'b0;
          win_last_q  <= 1'b0;
          if (num_layers_i == 10'd0 || num_rows_i < KP || num_cols_i < KP) begin
            degen_q <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            degen_q   <= 1'b0;
            arvalid_q <= 1'b1;
            araddr_q  <= base_addr_i;
            state_q   <= S_AR;
          end
        end
        S_AR: if (M_axi_arready_i) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          beat_q    <= '0;
          state_q   <= S_R;
        end
        S_R: if (M_axi_rvalid_i) begin
          beat_q <= beat_q + 8'd1;
          if (M_axi_rlast_i) begin
            rready_q <= 1'b0;
            wp_q     <= slot_add(wp_q, 1);
            fb_q <= fb_d; fl_q <= fl_d; fk_q <= fk_d;
            if (w_fetch_last) begin
              state_q <= S_DRAIN;
            end else if (w_nvalid_d < CW'(SLOTS)) begin
              arvalid_q <= 1'b1;
              araddr_q  <= row_addr(base_q, fl_d, fb_d + fk_d);
              state_q   <= S_AR;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: if (w_nvalid_d < CW'(SLOTS)) begin
          arvalid_q <= 1'b1;
          araddr_q  <= row_addr(base_q, fl_q, fb_q + fk_q);
          state_q   <= S_AR;
        end
        S_DRAIN: if (degen_q) begin
          degen_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (w_win_hs && win_last_q) begin
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        state_q <= S_IDLE;
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign M_axi_arid_o    = 4'd0;
  assign M_axi_araddr_o  = araddr_q;
  assign M_axi_arlen_o   = arlen_q;
  assign M_axi_arsize_o  = 3'($clog2(AXI_DATA_W / 8));
  assign M_axi_arburst_o = 2'b01;
  assign M_axi_arlock_o  = 1'b0;
  assign M_axi_arcache_o = 4'd3;
  assign M_axi_arprot_o  = 3'd0;
  assign M_axi_arqos_o   = 4'd0;
  assign M_axi_arvalid_o = arvalid_q;
  assign M_axi_rready_o  = rready_q;
  assign win_data_o      = win_data_q;
  assign win_valid_o     = win_valid_q;
  assign win_layer_o     = win_layer_q;
  assign win_row_o       = win_row_q;
  assign win_col_o       = win_col_q;

endmodule
`default_nettype wire

// File: tb/tb_input_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_window_streamer
// Purpose  : Scoreboard bench for input_window_streamer with an AXI read
//            slave model, expected AR and window queues, and directed jobs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_window_streamer;

  logic        clk, reset_n, start;
  logic [31:0] base_addr;
  logic [9:0]  num_layers, num_rows, num_cols;
  logic        busy, done;
  logic [3:0]  arid, arcache, arqos;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic        arlock, arvalid, arready;
  logic [63:0] rdata;
  logic        rlast, rvalid, rready;
  logic [71:0] win_data;
  logic        win_valid, win_ready;
  logic [9:0]  win_layer, win_row, win_col;

  input_window_streamer dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .base_addr_i(base_addr),
    .num_layers_i(num_layers), .num_rows_i(num_rows), .num_cols_i(num_cols),
    .busy_o(busy), .done_o(done),
    .M_axi_arid_o(arid), .M_axi_araddr_o(araddr), .M_axi_arlen_o(arlen),
    .M_axi_arsize_o(arsize), .M_axi_arburst_o(arburst), .M_axi_arlock_o(arlock),
    .M_axi_arcache_o(arcache), .M_axi_arprot_o(arprot), .M_axi_arqos_o(arqos),
    .M_axi_arvalid_o(arvalid), .M_axi_arready_i(arready),
    .M_axi_rdata_i(rdata), .M_axi_rresp_i(rresp), .M_axi_rlast_i(rlast),
    .M_axi_rvalid_i(rvalid), .M_axi_rready_o(rready),
    .win_data_o(win_data), .win_valid_o(win_valid), .win_ready_i(win_ready),
    .win_layer_o(win_layer), .win_row_o(win_row), .win_col_o(win_col)
  );

  typedef struct {
    logic [71:0] data;
    logic [9:0]  l, r, c;
  } win_t;

  win_t        exp_win[$];
  logic [31:0] exp_ar[$];
  logic [31:0] rq_addr[$];
  int          rq_len[$];

  int          n_tests = 0, n_fail = 0;
  logic [31:0] cur_base;
  int          cur_cols, cur_arlen, ar_stall;
  bit          rand_mode, ar_seen;
  bit          s_ar_hs, s_r_hs;
  logic [31:0] s_ar_addr;
  int          s_ar_len;
  bit          r_active;
  logic [31:0] r_addr;
  int          r_len, r_beat;
  bit          prev_arpend;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [7:0] pix(input int l, input int r, input int c);
    return 8'((l * 50 + r * 5 + c) & 255);
  endfunction

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int beat);
    logic [63:0] d;
    logic [31:0] off;
    int l, r, col;
    off = a - cur_base;
    l = int'(off >> 12);
    r = int'((off >> 6) & 32'd63);
    d = '0;
    for (int j = 0; j < 8; j++) begin
      col = beat * 8 + j;
      d[j*8 +: 8] = (col < cur_cols) ? pix(l, r, col) : 8'hEE;
    end
    return d;
  endfunction

  // Handshakes are observed mid-cycle; the slave reacts after the next edge.
  always @(negedge clk) begin
    s_ar_hs   = arvalid && arready;
    s_ar_addr = araddr;
    s_ar_len  = int'(arlen);
    s_r_hs    = rvalid && rready;
  end

  initial begin
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    r_active = 1'b0; r_beat = 0; r_len = 0; r_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        rq_addr.delete(); rq_len.delete();
        r_active = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
      end else begin
        if (s_ar_hs) begin
          rq_addr.push_back(s_ar_addr);
          rq_len.push_back(s_ar_len);
        end
        if (s_r_hs) begin
          if (rlast) r_active = 1'b0;
          else       r_beat++;
        end
        if (!r_active && rq_addr.size() > 0) begin
          r_addr = rq_addr.pop_front();
          r_len  = rq_len.pop_front();
          r_beat = 0;
          r_active = 1'b1;
        end
        if (ar_stall > 0) begin
          arready = 1'b0;
          if (arvalid) ar_stall--;
        end else begin
          arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (r_active) begin
          rvalid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
          rdata  = beat_data(r_addr, r_beat);
          rlast  = (r_beat == r_len);
          rresp  = 2'($urandom_range(0, 3));
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
    end
  end

  initial begin
    win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      win_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // AR monitor: address order, fixed attributes, and stability while stalled.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset_n) begin
      if (prev_arpend)
        check("ar_stable", {arvalid, araddr, arlen}, {1'b1, prev_addr, prev_len});
      if (arvalid) ar_seen = 1'b1;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          fail_msg("ar_unexpected");
        end else begin
          e = exp_ar.pop_front();
          check("ar_addr", araddr, e);
          check("ar_len", arlen, cur_arlen);
          check("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                {4'd0, 3'd3, 2'b01, 1'b0, 4'd3, 3'd0, 4'd0});
        end
      end
      prev_arpend = arvalid && !arready;
      prev_addr   = araddr;
      prev_len    = arlen;
    end else begin
      prev_arpend = 1'b0;
    end
  end

  // Window monitor: pops the scoreboard on every accepted window.
  always @(negedge clk) begin
    win_t w;
    if (reset_n && win_valid && win_ready) begin
      if (exp_win.size() == 0) begin
        fail_msg("win_unexpected");
      end else begin
        w = exp_win.pop_front();
        check("win_data", win_data, w.data);
        check("win_tag", {win_layer, win_row, win_col}, {w.l, w.r, w.c});
      end
    end
  end

  task automatic run_cfg(input logic [31:0] base, input int nl, input int nr, input int nc,
                         input bit rnd, input int stall);
    int   cyc;
    bit   degen;
    win_t w;
    degen     = (nl == 0) || (nr < 3) || (nc < 3);
    cur_base  = base;
    cur_cols  = nc;
    cur_arlen = (nc + 7) / 8 - 1;
    rand_mode = rnd;
    ar_stall  = stall;
    ar_seen   = 1'b0;
    if (!degen) begin
      for (int b = 0; b <= nr - 3; b++)
        for (int l = 0; l < nl; l++)
          for (int k = 0; k < 3; k++)
            if (!(nl == 1 && b > 0 && k < 2))
              exp_ar.push_back(base + 32'(l << 12) + 32'((b + k) << 6));
      for (int b = 0; b <= nr - 3; b++)
        for (int l = 0; l < nl; l++)
          for (int c = 0; c <= nc - 3; c++) begin
            w.data = '0;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                w.data[(8 - (i * 3 + j)) * 8 +: 8] = pix(l, b + i, c + j);
            w.l = 10'(l); w.r = 10'(b); w.c = 10'(c);
            exp_win.push_back(w);
          end
    end
    @(negedge clk);
    base_addr = base; num_layers = 10'(nl); num_rows = 10'(nr); num_cols = 10'(nc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("done_early", done, 1'b0);
    cyc = 1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) fail_msg("done_timeout");
    if (degen) begin
      check("degen_latency", cyc, 2);
      check("degen_no_ar", ar_seen, 1'b0);
    end
    check("win_left", exp_win.size(), 0);
    check("ar_left", exp_ar.size(), 0);
    check("busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    exp_win.delete();
    exp_ar.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {busy, done, arvalid, rready, win_valid}, 5'b0);
    check({tag, "_win"}, {win_data, win_layer, win_row, win_col}, '0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; start = 1'b0; base_addr = '0;
    num_layers = '0; num_rows = '0; num_cols = '0;
    rand_mode = 1'b0; ar_stall = 0; cur_base = '0; cur_cols = 0; cur_arlen = 0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cfg(32'h0000_0000, 1, 5, 5, 1'b0, 0);   // single layer 5x5
    run_cfg(32'h1000_0000, 2, 5, 5, 1'b1, 0);   // two layers, random handshakes
    run_cfg(32'h2000_0000, 1, 5, 5, 1'b0, 20);  // long arready stall
    run_cfg(32'h0000_0300, 1, 4, 12, 1'b1, 0);  // two beats per row
    run_cfg(32'h0000_0000, 1, 3, 3, 1'b0, 0);   // smallest legal image
    run_cfg(32'h0000_0000, 1, 2, 5, 1'b0, 0);   // too few rows
    run_cfg(32'h0000_0000, 0, 5, 5, 1'b0, 0);   // no layers
    run_cfg(32'h0000_0000, 1, 5, 2, 1'b0, 0);   // too few columns

    // Reset while the second beat of a three-beat burst is on the bus.
    cur_base = '0; cur_cols = 20; cur_arlen = 2; rand_mode = 1'b0; ar_stall = 0;
    exp_ar.push_back(32'h0);
    @(negedge clk);
    base_addr = '0; num_layers = 10'd1; num_rows = 10'd5; num_cols = 10'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rvalid && rready && r_beat == 1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) fail_msg("beat2_timeout");
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    reset_n = 1'b1;
    exp_ar.delete();
    exp_win.delete();
    repeat (2) @(negedge clk);
    run_cfg(32'h0000_0000, 1, 5, 5, 1'b0, 0);   // clean run after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
